instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Front end of the single-issue RISC-V core: owns the program counter and drives the address input of the combinational instruction memory (instrMem).
- Captures each returned instruction word, with its PC, into a small FIFO fetch queue.
- Presents the queue head to the decoder over a valid/ready handshake.
- Accepts redirects (taken branch, JAL/JALR) from execute and flushes wrong-path words.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word aligned.
QUEUE_DEPTH, 2, fetch queue entries; power of two, 2..8.

Ports:
clk  input  1  core clock; all state updates on rising edge.
reset_n  input  1  asynchronous, active-low reset.
instr_addr  output  32  byte address to instrMem; equals internal PC register.
instr_in  input  32  instruction word returned combinationally by instrMem for instr_addr.
redirect_valid  input  1  execute requests PC change this cycle.
redirect_target  input  32  new byte PC; valid when redirect_valid=1.
out_valid  output  1  queue head holds a valid instruction.
out_instr  output  32  instruction at queue head.
out_pc  output  32  PC of instruction at queue head.
out_ready  input  1  decoder accepts head this cycle.
misalign_fault  output  1  sticky flag: redirect_target[1:0] != 0 was received.

Behaviour:
- Reset (async assert, sync-safe deassert): pc=RESET_PC, count=0, rd_ptr=wr_ptr=0, misalign_fault=0. Outputs: out_valid=0, out_instr=0, out_pc=0, instr_addr=RESET_PC.
- Reset asserted mid-operation discards all queue contents and any pending redirect immediately.
- pop = out_valid & out_ready. Head leaves the queue at the clock edge.
- fetch = (count < QUEUE_DEPTH) | pop. Full-and-popping still fetches in the same cycle.
- On fetch without redirect:
  - write {pc, instr_in} at wr_ptr; wr_ptr++ modulo QUEUE_DEPTH.
  - pc <= pc + 4, 32-bit wrap: 32'hFFFF_FFFC -> 32'h0000_0000.
- Queue full and no pop: no write, pc holds, instr_addr stable.
- Latency: word at address A appears at out_* on the cycle after instr_addr=A, when the queue was empty.
- count update: +1 on fetch only, -1 on pop only, unchanged on both or neither.
- out_valid = (count != 0). out_instr/out_pc driven from the head entry; driven 0 when count=0.
- Redirect (redirect_valid=1), aligned target (target[1:0]==0):
  - at the edge, count=0 and rd_ptr=wr_ptr=0.
  - pc <= redirect_target; no fetch write this cycle.
  - next cycle instr_addr=redirect_target; its word reaches out_* one cycle later, giving a 2-cycle redirect penalty.
- Redirect with simultaneous pop: the pop is honoured (decoder consumed the head), then the flush applies. Redirect overrides fetch.
- Redirect with misaligned target:
  - misalign_fault <= 1, sticky until reset.
  - queue is still flushed; pc <= {redirect_target[31:2], 2'b00}.
- Back-to-back redirects: each flushes; the last one wins.
- No internal FSM beyond the queue; state = pc, pointers, count, fault.
- Storage is plain registers; no memory inference required.

Decomposition:
- Shared package/header rv_core_defs:
  - XLEN=32, INSTR_BYTES=4, RESET_PC default.
  - NOP encoding 32'h0000_0013 (ADDI x0,x0,0).
- One natural sub-module: fetch_queue, a parameterised sync FIFO with flush.
  - Ports: clk, reset_n, push, push_data[63:0], pop, flush, head_data, count.
- instr_fetch_unit holds the pc register, next-pc mux and fault flag.

Test Plan:
- Reset, then out_ready=1 constantly with instrMem returning 32'h0010_0093 at address 0 -> cycle 1: out_valid=1, out_pc=0, out_instr=32'h0010_0093. Cycle 2: out_pc=4. Sequential +4 thereafter.
- out_ready=0 from reset -> count reaches 2 after 2 cycles, instr_addr frozen at 8, out_pc stays 0. Raise out_ready for one cycle -> pc advances to 12 and out_pc=4 next cycle.
- Full queue with pop and fetch in the same cycle -> count stays 2, pc +4, ordering preserved (out_pc 0,4,8,...).
- redirect_valid=1 with target 32'h0000_0020 while queue holds 2 entries -> next cycle out_valid=0, instr_addr=0x20. Following cycle out_pc=0x20.
- redirect with target 32'h0000_0022 -> misalign_fault=1 (sticky), instr_addr=0x20. reset_n pulse low -> fault=0, instr_addr=RESET_PC.
- RESET_PC=32'hFFFF_FFF8, out_ready=1 -> out_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000 (wrap).

Source files
------------

// File: rtl/rv_core_defs.sv
// Shared core definitions for the fetch front end: data widths, reset PC
// and a helper that forces a byte address onto a word boundary.
package rv_core_defs;

  localparam int          XLEN             = 32;
  localparam int          INSTR_BYTES      = 4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

  // Clears the two byte-offset bits so the result is a legal fetch address.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small register-based synchronous FIFO holding {pc, instr} pairs; flush
// empties it and takes priority over any push or pop in the same cycle.
module fetch_queue
  import rv_core_defs::*;
#(
  parameter int DEPTH = 2,
  parameter int W     = 64,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  input  logic          flush,
  output logic [W-1:0]  head_data,
  output logic [CW-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_r [DEPTH];
  logic [PW-1:0] rd_ptr_r;
  logic [PW-1:0] wr_ptr_r;
  logic [CW-1:0] count_r;

  // Storage, pointers and occupancy; pointers wrap naturally (DEPTH is a power of two).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else if (flush) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + PW'(1);
      end
      if (pop) rd_ptr_r <= rd_ptr_r + PW'(1);
      case ({push, pop})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign head_data = (count_r != '0) ? mem_r[rd_ptr_r] : '0;
  assign count     = count_r;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch front end: owns the PC, drives instrMem, queues fetched words for the
// decoder and handles execute redirects including misaligned-target faults.
module instr_fetch_unit
  import rv_core_defs::*;
#(
  parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [31:0] instr_addr,
  input  logic [31:0] instr_in,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  input  logic        out_ready,
  output logic        misalign_fault
);

  localparam int CW = $clog2(QUEUE_DEPTH) + 1;

  logic [31:0]   pc_r;
  logic [31:0]   pc_next_s;
  logic          fault_r;
  logic [CW-1:0] count_s;
  logic [63:0]   head_s;
  logic          pop_s;
  logic          fetch_s;
  logic          push_s;

  assign pop_s   = out_valid & out_ready;
  assign fetch_s = (count_s < CW'(QUEUE_DEPTH)) | pop_s;
  assign push_s  = fetch_s & ~redirect_valid;

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH),
    .W     (64),
    .CW    (CW)
  ) u_queue (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push_s),
    .push_data ({pc_r, instr_in}),
    .pop       (pop_s),
    .flush     (redirect_valid),
    .head_data (head_s),
    .count     (count_s)
  );

  // Next-PC select: redirect beats sequential fetch; a stalled fetch holds.
  always_comb begin
    pc_next_s = pc_r;
    if (redirect_valid) begin
      pc_next_s = word_align(redirect_target);
    end else if (push_s) begin
      pc_next_s = pc_r + 32'(INSTR_BYTES);
    end else begin
      pc_next_s = pc_r;
    end
  end

  // PC register and sticky misalignment flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_r    <= RESET_PC;
      fault_r <= 1'b0;
    end else begin
      pc_r <= pc_next_s;
      if (redirect_valid && (redirect_target[1:0] != 2'b00)) fault_r <= 1'b1;
    end
  end

  assign instr_addr     = pc_r;
  assign out_valid      = (count_s != '0);
  assign out_pc         = head_s[63:32];
  assign out_instr      = head_s[31:0];
  assign misalign_fault = fault_r;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized scoreboard bench for instr_fetch_unit with a queue-level reference model.
module tb_instr_fetch_unit;

  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic        clk;
  logic        reset_n;
  logic [31:0] instr_addr;
  logic [31:0] instr_in;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_ready;
  logic        misalign_fault;

  int checks = 0;
  int errors = 0;

  // Reference model state: PC, architectural queue of {pc,word}, sticky fault.
  logic [31:0] mpc;
  logic [63:0] mq[$];
  logic        mfault;
  logic [63:0] sb[$];

  instr_fetch_unit #(.RESET_PC(RPC), .QUEUE_DEPTH(DEPTH)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .instr_addr      (instr_addr),
    .instr_in        (instr_in),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .out_valid       (out_valid),
    .out_instr       (out_instr),
    .out_pc          (out_pc),
    .out_ready       (out_ready),
    .misalign_fault  (misalign_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0010_0093;
  endfunction

  assign instr_in = mem_word(instr_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_state();
    chk("instr_addr", instr_addr, mpc);
    chk("out_valid", {31'd0, out_valid}, {31'd0, (mq.size() != 0)});
    chk("misalign_fault", {31'd0, misalign_fault}, {31'd0, mfault});
    if (mq.size() == 0) begin
      chk("empty_out_pc", out_pc, 32'd0);
      chk("empty_out_instr", out_instr, 32'd0);
    end else begin
      chk("head_pc", out_pc, mq[0][63:32]);
    end
  endtask

  // One cycle: check settled state, drive inputs, advance model across the next edge.
  task automatic step(input logic rdy, input logic rv, input logic [31:0] tgt);
    check_state();
    out_ready       = rdy;
    redirect_valid  = rv;
    redirect_target = tgt;
    if (rdy && mq.size() != 0) sb.push_back(mq.pop_front());
    if (rv) begin
      mq.delete();
      mpc = tgt & 32'hFFFF_FFFC;
      if (tgt[1:0] != 2'b00) mfault = 1'b1;
    end else if (mq.size() < DEPTH) begin
      mq.push_back({mpc, mem_word(mpc)});
      mpc = mpc + 32'd4;
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset_n        = 1'b0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    #2;
    mq.delete();
    sb.delete();
    mpc    = RPC;
    mfault = 1'b0;
    check_state();
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  // Monitor: every accepted handshake must match the oldest scoreboard entry.
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pop actual_pc=%h expected=none", out_pc);
      end else begin
        logic [63:0] e;
        e = sb.pop_front();
        chk("pop_pc", out_pc, e[63:32]);
        chk("pop_instr", out_instr, e[31:0]);
      end
    end
  end

  initial begin
    logic [31:0] t;
    reset_n         = 1'b0;
    out_ready       = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = 32'd0;
    mpc    = RPC;
    mfault = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Stall from reset: queue fills, PC freezes at 8.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'd0);
    chk("frozen_addr", instr_addr, 32'd8);
    step(1'b1, 1'b0, 32'd0);
    chk("after_pop_addr", instr_addr, 32'd12);
    // Full-and-popping streaming.
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'd0);
    // Redirect with a full queue, then misaligned redirect.
    step(1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b1, 32'h0000_0020);
    chk("redir_addr", instr_addr, 32'h0000_0020);
    step(1'b1, 1'b0, 32'd0);
    step(1'b1, 1'b1, 32'h0000_0022);
    chk("misalign_flag", {31'd0, misalign_fault}, 32'd1);
    step(1'b1, 1'b1, 32'hFFFF_FFF8);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'd0);
    do_reset();
    chk("reset_fault", {31'd0, misalign_fault}, 32'd0);

    // Randomized traffic, including back-to-back redirects and PC wrap.
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 3))
        0:       t = $urandom;
        1:       t = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
        2:       t = 32'($urandom_range(0, 255)) & 32'hFFFF_FFFC;
        default: t = 32'($urandom_range(0, 63));
      endcase
      if (i == 1500) do_reset();
      step($urandom_range(0, 3) != 0, $urandom_range(0, 11) == 0, t);
    end
    step(1'b0, 1'b0, 32'd0);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
